fft_frame_feeder: RTL and testbench
===================================

Name: fft_frame_feeder

Overview:
Source end of the FFT sample stream. Buffers free-running ADC samples, which have no backpressure, into whole frames of FFT_POINTS. It presents each frame on the sample_data/sample_valid/sample_ready/sample_last handshake that feeds the FFT engine wrapper's input. A frame is never started until it is fully buffered, so no gaps occur mid-frame. A partial frame corrupted by overflow or by enable loss is discarded whole.

Parameters:
INPUT_WIDTH, 12, ADC sample width (two's complement unless the optional feature is enabled).
FFT_POINTS, 1024, samples per frame; power of two, >= 8.
FIFO_DEPTH, 2048, buffer depth in samples; power of two, integer multiple of FFT_POINTS, >= 2*FFT_POINTS.

Ports:
clk  in  1  single clock for all logic
rst  in  1  synchronous, active-high reset
enable  in  1  capture enable; sampled each cycle
adc_data  in  INPUT_WIDTH  ADC sample
adc_valid  in  1  one-cycle qualifier per sample; cannot be stalled
sample_data  out  INPUT_WIDTH  frame sample to the FFT input
sample_valid  out  1  sample_data valid
sample_ready  in  1  downstream accept
sample_last  out  1  high with the final (FFT_POINTS-th) sample of a frame
frames_sent  out  16  count of frames fully handshaken; wraps
frames_dropped  out  16  count of partial frames discarded; wraps
overflow  out  1  sticky; set on the first dropped sample; cleared only by rst

Behaviour:
- Reset values: sample_valid=0, sample_last=0, sample_data=0, frames_sent=0, frames_dropped=0, overflow=0. All pointers are 0; FIFO is empty; the read FSM is IDLE. Reset mid-frame abandons all buffered data; sample_valid is 0 on the cycle after rst is sampled high.
- Write side keeps wr_ptr (next write), commit_ptr (start of the current partial frame) and wr_pos (0..FFT_POINTS-1).
- Write side on adc_valid && enable && !discard:
  - If not full, store the sample at wr_ptr, increment wr_ptr and wr_pos.
  - When wr_pos wraps from FFT_POINTS-1 to 0, set commit_ptr to the new wr_ptr. The frame is now committed.
- Full means wr_ptr - rd_ptr == FIFO_DEPTH. A write attempted while full triggers all of the following:
  - drop the sample;
  - set overflow;
  - rewind wr_ptr to commit_ptr;
  - increment frames_dropped;
  - enter discard state.
- Discard state: incoming samples are dropped while wr_pos keeps counting. Discard ends at the next wr_pos wrap, and capture resumes at the following frame boundary of the ADC stream.
- enable low: if wr_pos != 0, rewind wr_ptr to commit_ptr, clear wr_pos and increment frames_dropped (once per loss of enable). Capture restarts at wr_pos=0 when enable returns high. The read side is unaffected by enable.
- Read FSM:
  - IDLE: go to LOAD when commit_ptr - rd_ptr >= FFT_POINTS.
  - LOAD: issue the RAM read for rd_ptr (1-cycle read latency); go to STREAM.
  - STREAM: output register holds the sample; sample_valid=1.
    - On sample_valid && sample_ready: pop, advance rd_cnt, and prefetch the next sample so there are no bubbles within a frame.
    - sample_last=1 exactly when rd_cnt == FFT_POINTS-1.
    - The handshake on the last sample increments frames_sent, then goes to IDLE, or directly continues with the next frame if one is committed. Back-to-back frames are allowed.
- Latency: if the final write of a frame occurs in cycle N with the read FSM in IDLE, sample_valid first rises in cycle N+2.
- Holding rule: sample_data and sample_last stay stable while sample_valid && !sample_ready. sample_valid never drops mid-frame.
- Simultaneous write commit and read pop in the same cycle are both honoured. Full/occupancy are computed from pointers with one extra wrap bit.

Optional Feature:
FFT_FEEDER_OFFSET_BINARY_EN:
- Defined: adc_data is offset binary; the MSB is inverted on write, giving two's complement (0x000 -> 0x800, 0xFFF -> 0x7FF for 12 bits).
- Undefined: adc_data is stored unmodified.

Decomposition:
- Package fft_feeder_pkg:
  - read-FSM state enum (IDLE, LOAD, STREAM);
  - localparams PTR_W = $clog2(FIFO_DEPTH)+1 and POS_W = $clog2(FFT_POINTS);
  - counter width constant (16).
- Sub-module fft_feeder_ram: simple dual-port RAM, registered read, FIFO_DEPTH x INPUT_WIDTH.

Test Plan:
- Single frame: FFT_POINTS=8, FIFO_DEPTH=16, adc_data 0..7 each cycle, sample_ready=1 -> sample_valid at the cycle after write 7 plus 2; data 0..7 contiguous; sample_last only on 7; frames_sent=1.
- Backpressure: toggle sample_ready 1/0 each cycle during a frame -> each value held stable while stalled; no duplicates or skips; sample_last on the 8th accepted sample.
- Overflow: sample_ready=0; feed 20 samples with values 0..19 -> frames 0..7 and 8..15 retained; overflow=1 at sample 16; frames_dropped=1. Then raise sample_ready and continue samples 20..31 -> frames 0..7, then 8..15, then 24..31 are output (16..23 discarded).
- Enable loss: drop enable after 3 samples of a frame -> frames_dropped=1; that partial frame is never output; the next full 8 samples after re-enable are output intact.
- Reset mid-stream: assert rst during STREAM at rd_cnt=4 -> sample_valid=0 next cycle; all counters 0; the next frame starts cleanly from new ADC data.
- With FFT_FEEDER_OFFSET_BINARY_EN: input 0x000 and 0xFFF -> output 0x800 and 0x7FF.

Source files
------------

// File: rtl/fft_feeder_pkg.sv
// Shared types and sizing helpers for the FFT frame feeder.
package fft_feeder_pkg;

    // Read-side sequencer states
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STREAM
    } rd_state_e;

    // Width of the frames_sent / frames_dropped statistics counters
    localparam int CNT_W = 16;

    // Pointer width: buffer address bits plus one wrap bit, so that a
    // full buffer and an empty buffer give different pointer differences.
    function automatic int ptr_width(input int fifo_depth);
        return $clog2(fifo_depth) + 1;
    endfunction

    // Width of the in-frame sample position counter
    function automatic int pos_width(input int fft_points);
        return $clog2(fft_points);
    endfunction

endpackage

// File: rtl/fft_feeder_ram.sv
// Simple dual-port sample buffer: one write port, one read port with a
// registered read (data appears the cycle after the address).
module fft_feeder_ram #(
    parameter int DEPTH = 2048,
    parameter int WIDTH = 12,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // Storage write port
    // NOTE: the storage array has no reset; only the read register does.
    // Resetting a memory prevents RAM inference and buys nothing, since the
    // pointers already define which entries hold valid data.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read port; cleared on reset so the output starts at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fft_frame_feeder.sv
// FFT frame feeder: buffers a free-running ADC stream into whole frames
// and streams each complete frame on a valid/ready/last handshake.
// Optional build macro FFT_FEEDER_OFFSET_BINARY_EN: treat adc_data as offset
// binary and convert it to two's complement on write by flipping the MSB.
module fft_frame_feeder
    import fft_feeder_pkg::*;
#(
    parameter int INPUT_WIDTH = 12,
    parameter int FFT_POINTS  = 1024,
    parameter int FIFO_DEPTH  = 2048
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [INPUT_WIDTH-1:0] adc_data,
    input  logic                   adc_valid,
    output logic [INPUT_WIDTH-1:0] sample_data,
    output logic                   sample_valid,
    input  logic                   sample_ready,
    output logic                   sample_last,
    output logic [CNT_W-1:0]       frames_sent,
    output logic [CNT_W-1:0]       frames_dropped,
    output logic                   overflow
);

    localparam int PTR_W = ptr_width(FIFO_DEPTH);
    localparam int POS_W = pos_width(FFT_POINTS);
    localparam int AW    = PTR_W - 1;

    localparam logic [PTR_W-1:0] FRAME_LEN = PTR_W'(FFT_POINTS);
    localparam logic [PTR_W-1:0] FULL_LVL  = PTR_W'(FIFO_DEPTH);
    localparam logic [POS_W-1:0] LAST_POS  = POS_W'(FFT_POINTS - 1);

    // Write side state
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_commit_ptr;
    logic [POS_W-1:0] r_wr_pos;
    logic             r_discard;
    logic             r_overflow;
    logic [CNT_W-1:0] r_frames_dropped;

    // Read side state
    rd_state_e        r_state;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [POS_W-1:0] r_rd_cnt;
    logic             r_sample_valid;
    logic             r_sample_last;
    logic [CNT_W-1:0] r_frames_sent;

    logic [INPUT_WIDTH-1:0] w_wr_data;
    logic [INPUT_WIDTH-1:0] w_rd_data;
    logic                   w_full;
    logic                   w_wr_en;
    logic                   w_pos_last;
    logic [PTR_W-1:0]       w_commit_nxt;
    logic                   w_pop;
    logic [PTR_W-1:0]       w_rd_next;
    logic [AW-1:0]          w_rd_addr;
    logic                   w_frame_avail;
    logic                   w_next_frame_avail;

`ifdef FFT_FEEDER_OFFSET_BINARY_EN
    assign w_wr_data = {~adc_data[INPUT_WIDTH-1], adc_data[INPUT_WIDTH-2:0]};
`else
    assign w_wr_data = adc_data;
`endif

    // The slot behind the output register stays counted until it is popped,
    // so a stalled sample can never be overwritten.
    assign w_full     = (r_wr_ptr - r_rd_ptr) == FULL_LVL;
    assign w_wr_en    = adc_valid && enable && !r_discard && !w_full;
    assign w_pos_last = (r_wr_pos == LAST_POS);

    // Commit pointer as it will be after this edge; the read side looks at
    // it early so a freshly completed frame starts two cycles after its
    // final write.
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_commit_nxt = r_commit_ptr;
        if (w_wr_en && w_pos_last) begin
            w_commit_nxt = r_wr_ptr + PTR_W'(1);
        end
    end

    // Write side: capture, frame commit, overflow discard and enable loss
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr         <= '0;
            r_commit_ptr     <= '0;
            r_wr_pos         <= '0;
            r_discard        <= 1'b0;
            r_overflow       <= 1'b0;
            r_frames_dropped <= '0;
        end else if (!enable) begin
            // Abandon the partial frame; a frame already dropped by an
            // overflow discard is not counted a second time.
            if (r_wr_pos != '0) begin
                r_wr_ptr <= r_commit_ptr;
                r_wr_pos <= '0;
                if (!r_discard) begin
                    r_frames_dropped <= r_frames_dropped + CNT_W'(1);
                end
            end
            r_discard <= 1'b0;
        end else if (adc_valid) begin
            if (r_discard) begin
                // Skip the rest of the corrupted frame, staying frame-aligned
                r_wr_pos <= r_wr_pos + POS_W'(1);
                if (w_pos_last) begin
                    r_discard <= 1'b0;
                end
            end else if (w_full) begin
                // The overflowing sample belongs to the dropped frame, so it
                // still advances the position; at the last position the
                // discard is already complete.
                r_overflow       <= 1'b1;
                r_wr_ptr         <= r_commit_ptr;
                r_frames_dropped <= r_frames_dropped + CNT_W'(1);
                r_wr_pos         <= r_wr_pos + POS_W'(1);
                r_discard        <= !w_pos_last;
            end else begin
                r_wr_ptr     <= r_wr_ptr + PTR_W'(1);
                r_wr_pos     <= r_wr_pos + POS_W'(1);
                r_commit_ptr <= w_commit_nxt;
            end
        end
    end

    assign w_pop              = r_sample_valid && sample_ready;
    assign w_rd_next          = r_rd_ptr + PTR_W'(1);
    assign w_frame_avail      = (w_commit_nxt - r_rd_ptr) >= FRAME_LEN;
    assign w_next_frame_avail = (w_commit_nxt - w_rd_next) >= FRAME_LEN;

    // Read address: prefetch the following sample on a pop, otherwise keep
    // re-reading the current one so the output holds during a stall.
    always_comb begin
        w_rd_addr = r_rd_ptr[AW-1:0];
        if (w_pop) begin
            w_rd_addr = w_rd_next[AW-1:0];
        end
    end

    fft_feeder_ram #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (INPUT_WIDTH),
        .AW    (AW)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr[AW-1:0]),
        .i_wr_data (w_wr_data),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    // Read sequencer: wait for a committed frame, prime the RAM, stream it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_rd_ptr       <= '0;
            r_rd_cnt       <= '0;
            r_sample_valid <= 1'b0;
            r_sample_last  <= 1'b0;
            r_frames_sent  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_frame_avail) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_state        <= ST_STREAM;
                    r_sample_valid <= 1'b1;
                    r_sample_last  <= 1'b0;
                    r_rd_cnt       <= '0;
                end
                ST_STREAM: begin
                    if (w_pop) begin
                        r_rd_ptr <= w_rd_next;
                        if (r_rd_cnt == LAST_POS) begin
                            r_frames_sent <= r_frames_sent + CNT_W'(1);
                            r_rd_cnt      <= '0;
                            r_sample_last <= 1'b0;
                            if (!w_next_frame_avail) begin
                                r_state        <= ST_IDLE;
                                r_sample_valid <= 1'b0;
                            end
                        end else begin
                            r_rd_cnt      <= r_rd_cnt + POS_W'(1);
                            r_sample_last <= (r_rd_cnt + POS_W'(1)) == LAST_POS;
                        end
                    end
                end
                default: begin
                    r_state        <= ST_IDLE;
                    r_sample_valid <= 1'b0;
                    r_sample_last  <= 1'b0;
                end
            endcase
        end
    end

    assign sample_data    = w_rd_data;
    assign sample_valid   = r_sample_valid;
    assign sample_last    = r_sample_last;
    assign frames_sent    = r_frames_sent;
    assign frames_dropped = r_frames_dropped;
    assign overflow       = r_overflow;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Self-checking bench for fft_frame_feeder (8-point frames, 16-deep buffer).
// Expected samples go into a scoreboard queue as stimulus is driven and are
// compared whenever a handshake completes on the output.
module tb_fft_frame_feeder;

    localparam int W = 12;
    localparam int N = 8;
    localparam int D = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic [W-1:0]  adc_data = '0;
    logic          adc_valid = 1'b0;
    logic          sample_ready = 1'b0;
    logic [W-1:0]  sample_data;
    logic          sample_valid;
    logic          sample_last;
    logic [15:0]   frames_sent;
    logic [15:0]   frames_dropped;
    logic          overflow;

    int            n_checks = 0;
    int            n_fail = 0;
    int            exp_sent = 0;
    int            exp_dropped = 0;
    logic [W-1:0]  sb[$];

    // Monitor state
    int            acc_cnt = 0;
    logic          prev_stall = 1'b0;
    logic [W-1:0]  prev_data = '0;
    logic          prev_last = 1'b0;

    fft_frame_feeder #(
        .INPUT_WIDTH (W),
        .FFT_POINTS  (N),
        .FIFO_DEPTH  (D)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .adc_data       (adc_data),
        .adc_valid      (adc_valid),
        .sample_data    (sample_data),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .sample_last    (sample_last),
        .frames_sent    (frames_sent),
        .frames_dropped (frames_dropped),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected stored value for an ADC input word
    function automatic logic [W-1:0] conv(input logic [W-1:0] v);
`ifdef FFT_FEEDER_OFFSET_BINARY_EN
        return {~v[W-1], v[W-2:0]};
`else
        return v;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] v, input bit keep);
        tick();
        adc_valid = 1'b1;
        adc_data  = v;
        if (keep) sb.push_back(conv(v));
    endtask

    task automatic idle();
        tick();
        adc_valid = 1'b0;
    endtask

    task automatic drain(input string tag, input bit toggle);
        for (int c = 0; c < 200 && sb.size() != 0; c++) begin
            tick();
            if (toggle) sample_ready = ~sample_ready;
        end
        check(tag, sb.size(), 0);
        sample_ready = 1'b1;
        tick();
        tick();
    endtask

    // Output monitor: scoreboard compare, hold-while-stalled, no mid-frame gaps
    always @(negedge clk) begin
        logic [W-1:0] exp_v;
        if (rst) begin
            acc_cnt    = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", sample_valid, 1);
                check("hold_data", sample_data, prev_data);
                check("hold_last", sample_last, prev_last);
            end else if (acc_cnt != 0) begin
                check("no_gap", sample_valid, 1);
            end
            if (sample_valid && sample_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", sb.size(), 1);
                end else begin
                    exp_v = sb.pop_front();
                    check("data", sample_data, exp_v);
                    check("last", sample_last, (acc_cnt == N - 1));
                end
                acc_cnt = (acc_cnt + 1) % N;
            end
            prev_stall = sample_valid && !sample_ready;
            prev_data  = sample_data;
            prev_last  = sample_last;
        end
    end

    // Global time limit
    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, summary not printed");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] edge_vals [N];
        edge_vals = '{12'h000, 12'hFFF, 12'h800, 12'h7FF, 12'h001, 12'hFFE, 12'h555, 12'hAAA};

        // Reset values
        repeat (3) tick();
        check("rst_valid", sample_valid, 0);
        check("rst_last", sample_last, 0);
        check("rst_data", sample_data, 0);
        check("rst_sent", frames_sent, 0);
        check("rst_dropped", frames_dropped, 0);
        check("rst_overflow", overflow, 0);
        rst = 1'b0;
        enable = 1'b1;
        sample_ready = 1'b1;
        tick();

        // Single frame with first-valid latency
        for (int i = 0; i < N; i++) send(W'(i), 1);
        idle();
        @(negedge clk);
        check("latency_n1", sample_valid, 0);
        @(negedge clk);
        check("latency_n2", sample_valid, 1);
        drain("drain_single", 0);
        exp_sent++;
        check("sent_single", frames_sent, exp_sent);

        // Extreme sample values
        for (int i = 0; i < N; i++) send(edge_vals[i], 1);
        idle();
        drain("drain_edges", 0);
        exp_sent++;
        check("sent_edges", frames_sent, exp_sent);

        // Backpressure: sample_ready toggles every cycle
        for (int i = 0; i < N; i++) send(W'(12'h100 + i), 1);
        idle();
        drain("drain_backpressure", 1);
        exp_sent++;
        check("sent_backpressure", frames_sent, exp_sent);

        // Overflow: downstream stalled, 20 samples into a 16-deep buffer
        sample_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 16) check("ovf_before", overflow, 0);
            if (i == 17) check("ovf_set", overflow, 1);
            adc_valid = 1'b1;
            adc_data  = W'(12'h200 + i);
            if (i < 16) sb.push_back(conv(adc_data));
        end
        idle();
        exp_dropped++;
        check("dropped_ovf", frames_dropped, exp_dropped);
        check("sent_during_stall", frames_sent, exp_sent);
        sample_ready = 1'b1;
        for (int i = 20; i < 32; i++) send(W'(12'h200 + i), i >= 24);
        idle();
        drain("drain_overflow", 0);
        exp_sent += 3;
        check("sent_overflow", frames_sent, exp_sent);
        check("ovf_sticky", overflow, 1);

        // Enable loss after 3 samples of a frame
        for (int i = 0; i < 3; i++) send(W'(12'h300 + i), 0);
        tick();
        adc_valid = 1'b0;
        enable    = 1'b0;
        tick();
        tick();
        exp_dropped++;
        check("dropped_enable", frames_dropped, exp_dropped);
        enable = 1'b1;
        for (int i = 0; i < N; i++) send(W'(12'h310 + i), 1);
        idle();
        drain("drain_enable", 0);
        exp_sent++;
        check("sent_enable", frames_sent, exp_sent);
        check("dropped_enable_after", frames_dropped, exp_dropped);

        // Reset in the middle of a streamed frame (rd_cnt = 4)
        sample_ready = 1'b0;
        for (int i = 0; i < N; i++) send(W'(12'h400 + i), 1);
        idle();
        for (int c = 0; c < 20 && !sample_valid; c++) tick();
        check("rst_mid_wait_valid", sample_valid, 1);
        sample_ready = 1'b1;
        repeat (4) tick();
        sample_ready = 1'b0;
        check("rst_mid_sb_left", sb.size(), N - 4);
        rst = 1'b1;
        sb.delete();
        tick();
        check("rst_mid_valid", sample_valid, 0);
        check("rst_mid_data", sample_data, 0);
        check("rst_mid_last", sample_last, 0);
        check("rst_mid_sent", frames_sent, 0);
        check("rst_mid_dropped", frames_dropped, 0);
        check("rst_mid_overflow", overflow, 0);
        rst = 1'b0;
        exp_sent = 0;
        exp_dropped = 0;
        sample_ready = 1'b1;
        tick();
        for (int i = 0; i < N; i++) send(W'(12'h500 + i), 1);
        idle();
        drain("drain_after_reset", 0);
        exp_sent++;
        check("sent_after_reset", frames_sent, exp_sent);
        check("dropped_after_reset", frames_dropped, exp_dropped);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
